// File: rtl/text_console_writer.sv
`default_nettype none
// ============================================================================
// Module   : text_console_writer
// Purpose  : Character stream to text-buffer writer with cursor tracking and
//            line / screen clearing for a COLUMNS x ROWS cell grid.
// Revision : 1.0
// ============================================================================
module text_console_writer #(
  parameter int         COLUMNS = 40,
  parameter int         ROWS    = 15,
  parameter logic [6:0] BLANK   = 7'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [6:0]  char_in,
  output logic        char_ready,
  output logic        buffer_write_enable,
  output logic [11:0] position,
  output logic [6:0]  char_code,
  output logic [5:0]  cursor_column,
  output logic [3:0]  cursor_row
);

  localparam int c_cells = COLUMNS * ROWS;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PUT          = 2'd1,
    S_CLEAR_LINE   = 2'd2,
    S_CLEAR_SCREEN = 2'd3
  } state_t;

  state_t      r_state, w_state_next;
  logic [9:0]  r_count, w_count_next;
  logic [3:0]  r_line_row, w_line_row_next;
  logic        r_ready, w_ready_next;
  logic        r_we, w_we_next;
  logic [11:0] r_pos, w_pos_next;
  logic [6:0]  r_code, w_code_next;
  logic [5:0]  r_col, w_col_next;
  logic [3:0]  r_row, w_row_next;

  logic        w_accept;
  logic        w_printable;
  logic [3:0]  w_row_inc;
  logic [11:0] w_cursor_addr;
  logic [11:0] w_row_inc_base;
  logic [11:0] w_line_base;

  assign w_accept       = r_ready & char_valid;
  assign w_printable    = (char_in >= 7'h20) && (char_in <= 7'h7E);
  assign w_row_inc      = (r_row == 4'(ROWS - 1)) ? 4'd0 : r_row + 4'd1;
  assign w_cursor_addr  = 12'(r_row) * 12'(COLUMNS) + 12'(r_col);
  assign w_row_inc_base = 12'(w_row_inc) * 12'(COLUMNS);
  assign w_line_base    = 12'(r_line_row) * 12'(COLUMNS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_CLEAR_SCREEN;
      r_count    <= '0;
      r_line_row <= '0;
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_pos      <= '0;
      r_code     <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_line_row <= w_line_row_next;
      r_ready    <= w_ready_next;
      r_we       <= w_we_next;
      r_pos      <= w_pos_next;
      r_code     <= w_code_next;
      r_col      <= w_col_next;
      r_row      <= w_row_next;
    end
  end

  // Each branch computes the registered outputs for the cycle that follows;
  // the cursor only moves on the edge that issues an operation's last write.
  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_line_row_next = r_line_row;
    w_ready_next    = r_ready;
    w_we_next       = 1'b0;
    w_pos_next      = r_pos;
    w_code_next     = r_code;
    w_col_next      = r_col;
    w_row_next      = r_row;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_printable) begin
            w_we_next    = 1'b1;
            w_pos_next   = w_cursor_addr;
            w_code_next  = char_in;
            w_ready_next = 1'b0;
            if (r_col == 6'(COLUMNS - 1)) begin
              w_line_row_next = w_row_inc;
              w_count_next    = '0;
              w_state_next    = S_CLEAR_LINE;
            end else begin
              w_col_next   = r_col + 6'd1;
              w_state_next = S_PUT;
            end
          end else begin
            case (char_in)
              7'h0A: begin
                w_line_row_next = w_row_inc;
                w_we_next       = 1'b1;
                w_pos_next      = w_row_inc_base;
                w_code_next     = BLANK;
                w_count_next    = 10'd1;
                w_ready_next    = 1'b0;
                w_state_next    = S_CLEAR_LINE;
              end
              7'h0D: w_col_next = '0;
              7'h08: begin
                if (r_col != 6'd0) begin
                  w_col_next   = r_col - 6'd1;
                  w_we_next    = 1'b1;
                  w_pos_next   = w_cursor_addr - 12'd1;
                  w_code_next  = BLANK;
                  w_ready_next = 1'b0;
                  w_state_next = S_PUT;
                end
              end
              7'h0C: begin
                w_we_next    = 1'b1;
                w_pos_next   = '0;
                w_code_next  = BLANK;
                w_count_next = 10'd1;
                w_ready_next = 1'b0;
                w_state_next = S_CLEAR_SCREEN;
              end
              default: ;
            endcase
          end
        end
      end

      S_PUT: begin
        w_ready_next = 1'b1;
        w_state_next = S_IDLE;
      end

      S_CLEAR_LINE: begin
        w_we_next   = 1'b1;
        w_code_next = BLANK;
        w_pos_next  = w_line_base + 12'(r_count);
        if (r_count == 10'(COLUMNS - 1)) begin
          w_row_next   = r_line_row;
          w_col_next   = '0;
          w_state_next = S_PUT;
        end else begin
          w_count_next = r_count + 10'd1;
        end
      end

      S_CLEAR_SCREEN: begin
        w_we_next   = 1'b1;
        w_code_next = BLANK;
        w_pos_next  = 12'(r_count);
        if (r_count == 10'(c_cells - 1)) begin
          w_row_next   = '0;
          w_col_next   = '0;
          w_state_next = S_PUT;
        end else begin
          w_count_next = r_count + 10'd1;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign char_ready          = r_ready;
  assign buffer_write_enable = r_we;
  assign position            = r_pos;
  assign char_code           = r_code;
  assign cursor_column       = r_col;
  assign cursor_row          = r_row;

endmodule
`default_nettype wire
